// File: rtl/keypad_scan_reader.sv
// Row-strobe scanner and debouncer for a 4x4 active-low key matrix.
// It emits a one-cycle key event with its code and a held level while one key is stably pressed.
module keypad_scan_reader #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_col,
  output logic [3:0] o_row,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
  localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_KEY   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  logic [3:0]    col_meta_q, col_meta_d;
  logic [3:0]    col_sync_q, col_sync_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    row_q, row_d;

  logic          acc_hit_q, acc_hit_d;
  logic          acc_bad_q, acc_bad_d;
  logic [3:0]    acc_code_q, acc_code_d;

  logic          res_vld_q, res_vld_d;
  logic [1:0]    res_kind_q, res_kind_d;
  logic [3:0]    res_code_q, res_code_d;

  logic [1:0]    cand_kind_q, cand_kind_d;
  logic [3:0]    cand_code_q, cand_code_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]    stab_kind_q, stab_kind_d;
  logic [3:0]    stab_code_q, stab_code_d;

  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;

  // Row sample classification and frame accumulation temporaries
  logic          row_empty, row_hit;
  logic [1:0]    col_idx;
  logic          base_hit, base_bad;
  logic [3:0]    base_code;
  logic          new_hit, new_bad;
  logic [3:0]    new_code;

  always_comb begin
    row_empty = 1'b0;
    row_hit   = 1'b0;
    col_idx   = 2'd0;
    case (col_sync_q)
      4'b1111: row_empty = 1'b1;
      4'b1110: begin row_hit = 1'b1; col_idx = 2'd0; end
      4'b1101: begin row_hit = 1'b1; col_idx = 2'd1; end
      4'b1011: begin row_hit = 1'b1; col_idx = 2'd2; end
      4'b0111: begin row_hit = 1'b1; col_idx = 2'd3; end
      default: begin row_empty = 1'b0; row_hit = 1'b0; end
    endcase
  end

  always_comb begin
    col_meta_d  = i_col;
    col_sync_d  = col_meta_q;
    dwell_d     = dwell_q;
    row_idx_d   = row_idx_q;
    row_d       = row_q;
    acc_hit_d   = acc_hit_q;
    acc_bad_d   = acc_bad_q;
    acc_code_d  = acc_code_q;
    res_vld_d   = 1'b0;
    res_kind_d  = res_kind_q;
    res_code_d  = res_code_q;
    cand_kind_d = cand_kind_q;
    cand_code_d = cand_code_q;
    db_cnt_d    = db_cnt_q;
    stab_kind_d = stab_kind_q;
    stab_code_d = stab_code_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    // A new frame starts from a clean accumulator at row 0
    base_hit  = (row_idx_q == 2'd0) ? 1'b0 : acc_hit_q;
    base_bad  = (row_idx_q == 2'd0) ? 1'b0 : acc_bad_q;
    base_code = (row_idx_q == 2'd0) ? 4'd0 : acc_code_q;
    new_hit   = base_hit;
    new_bad   = base_bad;
    new_code  = base_code;
    if (row_hit) begin
      if (base_hit) begin
        new_bad = 1'b1;
      end else begin
        new_hit  = 1'b1;
        new_code = {row_idx_q, col_idx};
      end
    end else if (!row_empty) begin
      new_bad = 1'b1;
    end

    if (dwell_q == DWELL_LAST) begin
      dwell_d   = '0;
      row_idx_d = row_idx_q + 2'd1;
      row_d     = {row_q[2:0], row_q[3]};
      if (row_idx_q == 2'd3) begin
        res_vld_d  = 1'b1;
        res_kind_d = new_bad ? RES_MULTI : (new_hit ? RES_KEY : RES_NONE);
        res_code_d = (new_hit && !new_bad) ? new_code : 4'd0;
        acc_hit_d  = 1'b0;
        acc_bad_d  = 1'b0;
        acc_code_d = 4'd0;
      end else begin
        acc_hit_d  = new_hit;
        acc_bad_d  = new_bad;
        acc_code_d = new_code;
      end
    end else begin
      dwell_d = dwell_q + DWELL_ONE;
    end

    // Debounce runs one cycle after the frame result is registered
    if (res_vld_q) begin
      if (res_kind_q == RES_MULTI) begin
        cand_kind_d = RES_MULTI;
        cand_code_d = 4'd0;
        db_cnt_d    = '0;
      end else if (res_kind_q == cand_kind_q && res_code_q == cand_code_q) begin
        db_cnt_d = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + CNT_ONE;
      end else begin
        cand_kind_d = res_kind_q;
        cand_code_d = res_code_q;
        db_cnt_d    = CNT_ONE;
      end

      if (cand_kind_d != RES_MULTI && db_cnt_d == DB_MAX &&
          (cand_kind_d != stab_kind_q || cand_code_d != stab_code_q)) begin
        stab_kind_d = cand_kind_d;
        stab_code_d = cand_code_d;
        if (cand_kind_d == RES_KEY) begin
          key_code_d  = cand_code_d;
          key_held_d  = 1'b1;
          key_valid_d = 1'b1;
        end else begin
          key_held_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      dwell_q     <= '0;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      acc_hit_q   <= 1'b0;
      acc_bad_q   <= 1'b0;
      acc_code_q  <= 4'd0;
      res_vld_q   <= 1'b0;
      res_kind_q  <= RES_NONE;
      res_code_q  <= 4'd0;
      cand_kind_q <= RES_NONE;
      cand_code_q <= 4'd0;
      db_cnt_q    <= '0;
      stab_kind_q <= RES_NONE;
      stab_code_q <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      col_meta_q  <= col_meta_d;
      col_sync_q  <= col_sync_d;
      dwell_q     <= dwell_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      acc_hit_q   <= acc_hit_d;
      acc_bad_q   <= acc_bad_d;
      acc_code_q  <= acc_code_d;
      res_vld_q   <= res_vld_d;
      res_kind_q  <= res_kind_d;
      res_code_q  <= res_code_d;
      cand_kind_q <= cand_kind_d;
      cand_code_q <= cand_code_d;
      db_cnt_q    <= db_cnt_d;
      stab_kind_q <= stab_kind_d;
      stab_code_q <= stab_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign o_row       = row_q;
  assign o_key_code  = key_code_q;
  assign o_key_valid = key_valid_q;
  assign o_key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Bench for keypad_scan_reader with SCAN_DIV=4 and DEBOUNCE_SCANS=3, so one frame is 16 cycles.
// A matrix model answers the row strobes, and each expected key event is {cycle, code}.
module tb_keypad_scan_reader;

  localparam int W = 20;

  logic       clk;
  logic       rst;
  logic [3:0] i_col;
  logic [3:0] o_row;
  logic [3:0] o_key_code;
  logic       o_key_valid;
  logic       o_key_held;

  logic [3:0]   col_pat [4];
  logic [W-1:0] exp_q[$];
  int           cyc;
  int           checks;
  int           errors;

  keypad_scan_reader #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_col       (i_col),
    .o_row       (o_row),
    .o_key_code  (o_key_code),
    .o_key_valid (o_key_valid),
    .o_key_held  (o_key_held)
  );

  // Clock and cycle counter; cyc is k right after the k-th edge following reset release
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Matrix model: the strobed row returns its column pattern
  assign i_col = (o_row == 4'b1110) ? col_pat[0] :
                 (o_row == 4'b1101) ? col_pat[1] :
                 (o_row == 4'b1011) ? col_pat[2] :
                 (o_row == 4'b0111) ? col_pat[3] : 4'hF;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < k) begin
      checks++;
      errors++;
      $display("FAIL wait_cycle: reached %0d, expected %0d", cyc, k);
    end
  endtask

  task automatic release_keys();
    for (int r = 0; r < 4; r++) col_pat[r] = 4'hF;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    chk("reset_row",   32'(o_row),       32'hE);
    chk("reset_code",  32'(o_key_code),  32'h0);
    chk("reset_valid", 32'(o_key_valid), 32'h0);
    chk("reset_held",  32'(o_key_held),  32'h0);
    rst = 1'b0;
  endtask

  task automatic chk_drained(input string name);
    chk(name, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  // Scoreboard monitor: every key event must match the front of the expected queue
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && o_key_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: code=%0d at cyc=%0d, expected no pulse", o_key_code, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != {cyc[15:0], o_key_code} || o_key_held !== 1'b1) begin
          errors++;
          $display("FAIL key_event: cyc=%0d code=%0d held=%0b, expected cyc=%0d code=%0d held=1",
                   cyc, o_key_code, o_key_held, e[19:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] er;
    rst    = 1'b1;
    checks = 0;
    errors = 0;
    release_keys();

    // Idle scan: row pattern rotates every 4 cycles, no events
    do_reset(2);
    for (int i = 0; i < 32; i++) begin
      at_cyc(i);
      er = 4'b1111 ^ (4'b0001 << ((i / 4) % 4));
      chk("row_seq", 32'(o_row), 32'(er));
    end
    chk("idle_held", 32'(o_key_held), 32'h0);

    // Key 9, then move to key 3, then ghosting, then release
    do_reset(2);
    col_pat[2] = 4'b1101;
    exp_q.push_back({16'd49, 4'd9});
    at_cyc(48);  chk("k9_held_before", 32'(o_key_held), 32'h0);
    at_cyc(49);  chk("k9_held",        32'(o_key_held), 32'h1);
    chk("k9_code", 32'(o_key_code), 32'h9);
    at_cyc(80);
    col_pat[2] = 4'hF;
    col_pat[0] = 4'b0111;
    exp_q.push_back({16'd129, 4'd3});
    at_cyc(100); chk("move_held_mid",  32'(o_key_held), 32'h1);
    at_cyc(128); chk("move_held_pre",  32'(o_key_held), 32'h1);
    chk("move_code_pre", 32'(o_key_code), 32'h9);
    at_cyc(129); chk("move_code", 32'(o_key_code), 32'h3);
    chk("move_held", 32'(o_key_held), 32'h1);
    at_cyc(160);
    col_pat[0] = 4'b1010;
    at_cyc(240); chk("multi_held_kept", 32'(o_key_held), 32'h1);
    chk("multi_code_kept", 32'(o_key_code), 32'h3);
    release_keys();
    at_cyc(288); chk("rel_held_pre", 32'(o_key_held), 32'h0 + 32'h1);
    at_cyc(289); chk("rel_held",     32'(o_key_held), 32'h0);
    chk("rel_code_kept", 32'(o_key_code), 32'h3);
    at_cyc(320); chk("rel_held_late", 32'(o_key_held), 32'h0);
    chk_drained("events_drained_a");

    // Bounce: key seen only in alternate frames
    do_reset(2);
    for (int f = 0; f < 6; f++) begin
      col_pat[2] = (f % 2 == 0) ? 4'b1101 : 4'hF;
      at_cyc(16 * (f + 1));
    end
    release_keys();
    at_cyc(112);
    chk("bounce_held", 32'(o_key_held), 32'h0);
    chk("bounce_code", 32'(o_key_code), 32'h0);
    chk_drained("events_drained_b");

    // Two columns in one row from idle: MULTI every frame
    do_reset(2);
    col_pat[0] = 4'b1010;
    at_cyc(80);
    chk("multi_held", 32'(o_key_held), 32'h0);
    chk("multi_code", 32'(o_key_code), 32'h0);
    release_keys();
    at_cyc(112);
    chk("multi_rel_held", 32'(o_key_held), 32'h0);
    chk_drained("events_drained_c");

    // Reset one cycle after frame 2 discards partial debounce
    do_reset(2);
    col_pat[2] = 4'b1101;
    at_cyc(33);
    chk("pre_rst_held", 32'(o_key_held), 32'h0);
    do_reset(1);
    exp_q.push_back({16'd49, 4'd9});
    at_cyc(48);  chk("rst_held_before", 32'(o_key_held), 32'h0);
    at_cyc(49);  chk("rst_held",        32'(o_key_held), 32'h1);
    chk("rst_code", 32'(o_key_code), 32'h9);
    at_cyc(64);
    release_keys();
    chk_drained("events_drained_d");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
